pulse_gen: RTL and testbench
============================

Name: pulse_gen

Overview:
- Synchronous active-low pulse-train generator. It is the transmit-side counterpart of the pulse-meter input path on the servo board.
- Drives pulses at a programmed count, low width and high gap. Widths are chosen to survive the 8-bit input debouncer, which needs a low of at least 256 clk cycles.
- Used for loopback self-test of the pulse-meter input, and as a stimulus source for downstream counters.
- Runs on the 1.8432 MHz system clock.

Parameters:
- CNT_W, 16: width of the low-width and high-gap cycle counters.
- NUM_W, 8: width of the pulse-count request.

Ports:
- clk  in  1  system clock, 1.8432 MHz.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; accepted only when ready=1.
- num  in  NUM_W  number of pulses to emit; sampled on accept.
- low_cyc  in  CNT_W  low-phase width in clk cycles; sampled on accept.
- high_cyc  in  CNT_W  high-gap width in clk cycles; sampled on accept.
- ready  out  1  high in IDLE; accept occurs when start & ready.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  single-cycle completion flag.
- pout  out  1  registered active-low pulse output; idles high.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: pout=1, ready=1, busy=0, done=0; state=IDLE; all counters 0.
- Reset asserted mid-pulse forces pout high immediately. No completion is reported.
- States: IDLE, LOW, HIGH, FIN.
- IDLE: ready=1. On start:
  - latch num, low_cyc and high_cyc;
  - effective width = max(value, 1) for both low and high;
  - if num==0, go to FIN (no pulse emitted), else go to LOW.
- Latency: accept on cycle N → pout=0 on cycle N+1.
- LOW: pout=0 for exactly eff_low cycles. Then decrement the remaining count and go to HIGH.
- HIGH: pout=1 for exactly eff_high cycles. The gap is also applied after the final pulse. Then:
  - remaining>0 → LOW;
  - remaining==0 → FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE. ready returns to 1 the cycle after done.
- Total busy span for num=k: k*(eff_low+eff_high) cycles, plus 1 FIN cycle.
- Boundary conditions:
  - start while not ready: ignored; no queueing.
  - Inputs changing while busy: no effect.
  - Counters are loaded with eff-1, count down to 0, and never wrap.
  - num = 2^NUM_W-1 is legal.
  - start held continuously: a new accept occurs each time IDLE is re-entered.
- pout is driven directly from a flop; no combinational path from inputs.

Optional Feature:
- Macro: PULSEGEN_ABORT_EN.
- Defined:
  - adds input port abort (1 bit);
  - abort during LOW finishes the current low phase, so no runt pulse, then jumps to FIN;
  - abort during HIGH jumps to FIN the next cycle;
  - abort in IDLE or FIN is ignored;
  - abort takes priority over starting the next pulse.
- Undefined: no abort port; every accepted request runs to completion.

Decomposition:
- Shared package pulse_pkg:
  - state enum (IDLE, LOW, HIGH, FIN);
  - constant DEB_MIN_LOW = 256, the debouncer minimum low width;
  - constant SYS_CLK_HZ = 1843200.
- One natural sub-module: pulse_timer. It is a loadable CNT_W down-counter with load, en and zero flag, instantiated once and reloaded per phase.

Test Plan:
- Reset release, no start → pout=1, ready=1, busy=0, done=0 held for 1000 cycles.
- start with num=3, low_cyc=300, high_cyc=500:
  - exactly 3 low pulses, each 300 cycles, with 500-cycle gaps;
  - first fall 1 cycle after accept;
  - done exactly 2400 cycles after the first fall, then ready=1.
- num=0 → no pout transition; done 1 cycle after accept.
- low_cyc=0, high_cyc=0, num=2 → pulses 1 cycle low, 1 high; done after 4 cycles.
- rst_n dropped mid-LOW of a num=5 job → pout=1 asynchronously, done never asserts; after release a new job runs normally.
- Loopback pout into the debouncer with low_cyc=300, num=10 → exactly 10 debounced pulse flags.
- PULSEGEN_ABORT_EN: abort 50 cycles into the second low → that low still lasts the full 300 cycles, then done; 2 pulses total.

Source files
------------

// File: rtl/pulse_pkg.sv
// pulse_pkg: shared state encoding and board constants for the pulse generator
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Shortest low the 8-bit input debouncer on the pulse-meter path accepts
    localparam int DEB_MIN_LOW = 256;
    localparam int SYS_CLK_HZ  = 1843200;

endpackage

// File: rtl/pulse_timer.sv
// pulse_timer: loadable down-counter that stops at zero and flags it
module pulse_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load wins over counting; counting halts at zero so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: active-low pulse-train generator; define PULSEGEN_ABORT_EN to add the abort input
module pulse_gen
    import pulse_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef PULSEGEN_ABORT_EN
    input  logic             abort,
`endif
    input  logic [NUM_W-1:0] num,
    input  logic [CNT_W-1:0] low_cyc,
    input  logic [CNT_W-1:0] high_cyc,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             pout
);

    state_e           state_q;
    logic [NUM_W-1:0] rem_q;
    logic [CNT_W-1:0] low_q, high_q;
    logic [CNT_W-1:0] low_in, high_in, tmr_val;
    logic             ready_q, busy_q, done_q, pout_q, abort_q;
    logic             abort_w, accept, tmr_load, tmr_en, tmr_zero;

`ifdef PULSEGEN_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Phase timer holds (width-1); it is reloaded on accept and at every phase end
    always_comb begin
        accept   = (state_q == IDLE) && start;
        low_in   = (low_cyc == '0) ? '0 : low_cyc - CNT_W'(1);
        high_in  = (high_cyc == '0) ? '0 : high_cyc - CNT_W'(1);
        tmr_en   = (state_q == LOW) || (state_q == HIGH);
        tmr_load = accept || (tmr_en && tmr_zero);
        tmr_val  = (state_q == IDLE) ? low_in : (state_q == LOW) ? high_q : low_q;
    end

    pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Sequencer with all outputs registered so pout never sees an input combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            low_q   <= '0;
            high_q  <= '0;
            abort_q <= 1'b0;
            pout_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    low_q   <= low_in;
                    high_q  <= high_in;
                    rem_q   <= num;
                    abort_q <= 1'b0;
                    ready_q <= 1'b0;
                    if (num == '0) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= LOW;
                        pout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                LOW: begin
                    // An abort is remembered so the current low still completes in full
                    if (abort_w) abort_q <= 1'b1;
                    if (tmr_zero) begin
                        rem_q  <= rem_q - NUM_W'(1);
                        pout_q <= 1'b1;
                        if (abort_q || abort_w) begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= HIGH;
                        end
                    end
                end
                HIGH: begin
                    if (abort_w || (tmr_zero && rem_q == '0)) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tmr_zero) begin
                        state_q <= LOW;
                        pout_q  <= 1'b0;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    abort_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign pout  = pout_q;

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed vector bench for pulse_gen (abort cases when PULSEGEN_ABORT_EN is defined)
module tb_pulse_gen;
    import pulse_pkg::*;

    localparam int CNT_W = 16;
    localparam int NUM_W = 8;
    localparam int LIMIT = 20000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
`ifdef PULSEGEN_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic [NUM_W-1:0] num = '0;
    logic [CNT_W-1:0] low_cyc = '0;
    logic [CNT_W-1:0] high_cyc = '0;
    logic             ready, busy, done, pout;

    int total = 0;
    int bad = 0;

    typedef struct {
        int n;
        int lo;
        int hi;
        int falls;
        int lowrun;
        int hitot;
        int done_t;
        int flags;
        int abort_at;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pulse_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef PULSEGEN_ABORT_EN
        .abort    (abort),
`endif
        .num      (num),
        .low_cyc  (low_cyc),
        .high_cyc (high_cyc),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .pout     (pout)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one request; time t counts cycles after the accepting edge
    task automatic run_job(input vec_t v, input string tag);
        int t, falls, first_fall, cur, lo_min, lo_max, hitot, flags, deb;
        logic prev;
        @(negedge clk);
        check($sformatf("%s ready_pre", tag), ready, 1);
        start = 1'b1;
        num = NUM_W'(v.n);
        low_cyc = CNT_W'(v.lo);
        high_cyc = CNT_W'(v.hi);
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s busy1", tag), busy, (v.n != 0) ? 1 : 0);
        check($sformatf("%s ready1", tag), ready, 0);
        t = 1; falls = 0; first_fall = 0; cur = 0; lo_min = 1 << 30; lo_max = 0;
        hitot = 0; flags = 0; deb = 0; prev = 1'b1;
        forever begin
            if (prev && !pout) begin
                falls++;
                if (first_fall == 0) first_fall = t;
            end
            if (!pout) begin
                cur++;
                deb++;
                if (deb == DEB_MIN_LOW) flags++;
            end else begin
                if (cur > 0) begin
                    lo_min = (cur < lo_min) ? cur : lo_min;
                    lo_max = (cur > lo_max) ? cur : lo_max;
                end
                cur = 0;
                deb = 0;
                if (falls > 0 && !done) hitot++;
            end
            prev = pout;
            if (done || t >= LIMIT) break;
            if (t == 3) begin
                start = 1'b1;
                num = NUM_W'(v.n + 1);
                low_cyc = CNT_W'(v.lo + 7);
                high_cyc = CNT_W'(v.hi + 9);
            end
            if (t == 4) begin
                start = 1'b0;
                num = '0;
                low_cyc = '0;
                high_cyc = '0;
            end
`ifdef PULSEGEN_ABORT_EN
            abort = (t == v.abort_at);
`endif
            @(negedge clk);
            t++;
        end
        start = 1'b0;
`ifdef PULSEGEN_ABORT_EN
        abort = 1'b0;
`endif
        if (!done) check($sformatf("%s timeout", tag), 1, 0);
        check($sformatf("%s falls", tag), falls, v.falls);
        check($sformatf("%s first_fall", tag), first_fall, (v.falls > 0) ? 1 : 0);
        if (v.falls > 0) begin
            check($sformatf("%s low_min", tag), lo_min, v.lowrun);
            check($sformatf("%s low_max", tag), lo_max, v.lowrun);
        end
        check($sformatf("%s high_total", tag), hitot, v.hitot);
        check($sformatf("%s done_t", tag), t, v.done_t);
        check($sformatf("%s deb_flags", tag), flags, v.flags);
        check($sformatf("%s busy_at_done", tag), busy, 0);
        @(negedge clk);
        check($sformatf("%s ready_after", tag), ready, 1);
        check($sformatf("%s done_after", tag), done, 0);
    endtask

    initial begin
        int err, falls, dn, w;
        logic prev;
        //            n    lo   hi  falls lowrun hitot done_t flags abort_at
        vecs.push_back('{3,   300, 500, 3,   300,  1500, 2401,  3,  -1});
        vecs.push_back('{0,   300, 500, 0,   0,    0,    1,     0,  -1});
        vecs.push_back('{2,   0,   0,   2,   1,    2,    5,     0,  -1});
        vecs.push_back('{1,   1,   1,   1,   1,    1,    3,     0,  -1});
        vecs.push_back('{4,   2,   3,   4,   2,    12,   21,    0,  -1});
        vecs.push_back('{1,   256, 0,   1,   256,  1,    258,   1,  -1});
        vecs.push_back('{1,   255, 2,   1,   255,  2,    258,   0,  -1});
        vecs.push_back('{255, 0,   0,   255, 1,    255,  511,   0,  -1});
        vecs.push_back('{10,  300, 300, 10,  300,  3000, 6001,  10, -1});
`ifdef PULSEGEN_ABORT_EN
        vecs.push_back('{3,   300, 300, 2,   300,  300,  901,   2,  651});
        vecs.push_back('{3,   10,  10,  1,   10,   5,    16,    0,  15});
`endif

        #2 rst_n = 1'b0;
        #1;
        check("rst pout", pout, 1);
        check("rst ready", ready, 1);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        err = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({pout, ready, busy, done} != 4'b1100) err++;
        end
        check("idle_hold errors", err, 0);

        foreach (vecs[i]) run_job(vecs[i], $sformatf("v%0d", i));

        // start held high: a new request is taken each time IDLE comes back
        @(negedge clk);
        start = 1'b1;
        num = NUM_W'(1);
        low_cyc = CNT_W'(1);
        high_cyc = CNT_W'(1);
        falls = 0; dn = 0; prev = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (prev && !pout) falls++;
            if (done) dn++;
            prev = pout;
        end
        start = 1'b0;
        check("held_start falls", falls, 2);
        check("held_start dones", dn, 2);
        w = 0;
        while (!ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("held_start ready", ready, 1);

        // reset in the middle of a low phase
        @(negedge clk);
        start = 1'b1;
        num = NUM_W'(5);
        low_cyc = CNT_W'(300);
        high_cyc = CNT_W'(300);
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_low pout", pout, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst pout", pout, 1);
        check("async_rst ready", ready, 1);
        check("async_rst busy", busy, 0);
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("rst_no_done", dn, 0);
        check("rst_ready", ready, 1);
        run_job(vecs[2], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
